fm_stream_receiver: RTL and testbench
=====================================

FM_STREAM_RECEIVER -- requirements
Module: fm_stream_receiver

Interface
REQ-001 SHALL have parameter FM_WIDTH, default 4, pixels per line.
REQ-002 SHALL have parameter FM_HEIGHT, default 4, lines per frame.
REQ-003 SHALL have parameter DATA_W, default 16, pixel width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_vsync  input  1  frame-active level from the feature-map transmitter.
REQ-007 SHALL have port in_href  input  1  line-active level; a pixel is valid when in_vsync && in_href.
REQ-008 SHALL have port in_data  input  DATA_W  pixel.
REQ-009 SHALL have port rd_en  input  1  buffer read strobe.
REQ-010 SHALL have port rd_addr  input  10  read address, 0..FM_WIDTH*FM_HEIGHT-1.
REQ-011 SHALL have port rd_release  input  1  consumer frees the held frame.
REQ-012 SHALL have port rd_data  output  DATA_W  read data.
REQ-013 SHALL have port rd_valid  output  1  rd_data qualifier.
REQ-014 SHALL have port frame_valid  output  1  a complete, correct frame is held.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse on frame acceptance.
REQ-016 SHALL have port geom_err  output  1  one-cycle pulse on rejected frame.
REQ-017 SHALL have port frame_drop  output  1  one-cycle pulse when a frame is ignored because the buffer is held.
REQ-018 SHALL have port err_cnt  output  8  rejected-frame count (see Configuration).

Function
REQ-019 SHALL implement states IDLE, LINE, BLANK, HOLD, SKIP.
REQ-020 IDLE: in_vsync rising edge -> LINE if frame_valid=0 (or rd_release same cycle), else SKIP with frame_drop pulse.
REQ-021 LINE: each valid pixel written at line_cnt*FM_WIDTH+pix_cnt, pix_cnt+1; writes with pix_cnt>=FM_WIDTH or line_cnt>=FM_HEIGHT suppressed and flag length error.
REQ-022 LINE: in_href fall -> BLANK, line_cnt+1; pix_cnt!=FM_WIDTH flags length error; pix_cnt cleared.
REQ-023 BLANK: in_href rise -> LINE; no blanking-length requirement.
REQ-024 in_vsync fall in LINE or BLANK -> if no error flag and line_cnt==FM_HEIGHT: HOLD, frame_valid=1, frame_done pulse next cycle; else IDLE, geom_err pulse next cycle, frame_valid stays 0.
REQ-025 in_vsync fall while in_href high SHALL count as line end then frame end in one cycle.
REQ-026 HOLD: rd_release -> IDLE, frame_valid=0 next cycle; in_vsync rise while held -> SKIP, frame_drop.
REQ-027 SKIP: ignore all pixels; in_vsync fall -> HOLD if frame_valid=1, else IDLE.
REQ-028 in_href without in_vsync SHALL be ignored in all states.
REQ-029 Read: rd_en at cycle N -> rd_data and rd_valid=1 at N+1; rd_valid=0 otherwise; reads allowed in any state; rd_addr out of range returns 0.
REQ-030 Buffer SHALL be a simple dual-port memory of FM_WIDTH*FM_HEIGHT words; simultaneous read/write of one address returns old data.
REQ-031 Counters SHALL be 7 bits each; wrap never occurs within valid parameter range (FM_WIDTH, FM_HEIGHT <= 64).

Reset
REQ-032 rst SHALL force IDLE; frame_valid, frame_done, geom_err, frame_drop, rd_valid, err_cnt, counters, error flag = 0; rd_data = 0.
REQ-033 Reset mid-frame SHALL abandon the frame; capture resumes only on the next in_vsync rising edge; memory contents not cleared.

Configuration
REQ-034 Macro FM_RX_ERR_CNT_EN defined: err_cnt increments on each geom_err pulse, saturating at 255, cleared by rst.
REQ-035 Macro FM_RX_ERR_CNT_EN undefined: err_cnt tied to 0, counter logic absent; all else identical.

Verification (FM_WIDTH=4, FM_HEIGHT=4)
REQ-036 Frame of 4 lines x 4 pixels data 0..15, 16-cycle blanking -> frame_done once, frame_valid=1, reads of addr 0..15 return 0..15 one cycle later.
REQ-037 Line 2 carrying 3 pixels -> geom_err pulse, frame_valid=0, err_cnt=1 (macro on) / 0 (off).
REQ-038 Second frame while frame_valid=1, no release -> frame_drop pulse, buffer still holds first frame's 0..15.
REQ-039 rd_release in same cycle as next in_vsync rise -> second frame captured, frame_done, new data readable.
REQ-040 rst asserted after line 1, then full clean frame -> frame_done once, correct data, no geom_err.
REQ-041 5 lines of 4 pixels -> geom_err, line 5 not written, frame_valid=0.

Source files
------------

// File: rtl/fm_stream_receiver.sv
`default_nettype none
// ============================================================================
// Module   : fm_stream_receiver
// Purpose  : Captures one feature-map frame from a vsync/href pixel stream into
//            a FM_WIDTH*FM_HEIGHT dual-port buffer. It checks the geometry of
//            every frame. It holds an accepted frame until the consumer
//            releases it, and drops frames that arrive while a frame is held.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_vsync/in_href    - frame / line active levels
//            in_data             - pixel, valid when in_vsync && in_href
//            rd_en/rd_addr       - buffer read, data one cycle later
//            rd_release          - consumer frees the held frame
//            rd_data/rd_valid    - read data and qualifier
//            frame_valid         - a complete, correct frame is held
//            frame_done/geom_err/frame_drop - one-cycle event pulses
//            err_cnt             - rejected-frame counter
// Config   : define FM_RX_ERR_CNT_EN to enable the saturating err_cnt counter;
//            when it is undefined, err_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module fm_stream_receiver #(
  parameter int FM_WIDTH  = 4,
  parameter int FM_HEIGHT = 4,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vsync,
  input  logic              in_href,
  input  logic [DATA_W-1:0] in_data,
  input  logic              rd_en,
  input  logic [9:0]        rd_addr,
  input  logic              rd_release,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              frame_valid,
  output logic              frame_done,
  output logic              geom_err,
  output logic              frame_drop,
  output logic [7:0]        err_cnt
);

  localparam int         DEPTH   = FM_WIDTH * FM_HEIGHT;
  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0] W7      = 7'(FM_WIDTH);
  localparam logic [6:0] H7      = 7'(FM_HEIGHT);
  localparam logic [13:0] DEPTH14 = 14'(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LINE  = 3'd1,
    BLANK = 3'd2,
    HOLD  = 3'd3,
    SKIP  = 3'd4
  } state_t;

  state_t      r_state, w_state_n;
  logic [6:0]  r_pix_cnt, w_pix_n;
  logic [6:0]  r_line_cnt, w_line_n;
  logic        r_err, w_err_n;
  logic        r_frame_valid, w_fv_n;
  logic        r_done, w_done_n;
  logic        r_gerr, w_gerr_n;
  logic        r_drop, w_drop_n;
  logic        r_vs_d, r_px_d;
  logic        w_px, w_vs_rise, w_vs_fall;
  logic        w_we;
  logic [AW-1:0] w_waddr;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  // The edge-detect history is intentionally not reset. A vsync that is still
  // high when reset lifts must not look like a fresh frame start. Capture
  // resumes only on a genuine rising edge.
  always_ff @(posedge clk) begin
    r_vs_d <= in_vsync;
    r_px_d <= in_vsync & in_href;
  end

  assign w_px      = in_vsync & in_href;
  assign w_vs_rise = in_vsync & ~r_vs_d;
  assign w_vs_fall = ~in_vsync & r_vs_d;
  assign w_waddr   = AW'(14'(r_line_cnt) * 14'(W7) + 14'(r_pix_cnt));

  always_comb begin
    w_state_n = r_state;
    w_pix_n   = r_pix_cnt;
    w_line_n  = r_line_cnt;
    w_err_n   = r_err;
    w_fv_n    = r_frame_valid;
    w_done_n  = 1'b0;
    w_gerr_n  = 1'b0;
    w_drop_n  = 1'b0;
    w_we      = 1'b0;
    case (r_state)
      IDLE, HOLD: begin
        // frame_valid is always 0 in IDLE, so one rule covers both states.
        if (w_vs_rise) begin
          if (!r_frame_valid || rd_release) begin
            w_state_n = LINE;
            w_pix_n   = '0;
            w_line_n  = '0;
            w_err_n   = 1'b0;
            w_fv_n    = 1'b0;
          end else begin
            w_state_n = SKIP;
            w_drop_n  = 1'b1;
          end
        end else if (rd_release && r_state == HOLD) begin
          w_state_n = IDLE;
          w_fv_n    = 1'b0;
        end
      end
      LINE, BLANK: begin
        if (w_px) begin
          w_state_n = LINE;
          if (r_pix_cnt >= W7 || r_line_cnt >= H7) w_err_n = 1'b1;
          else                                     w_we    = 1'b1;
          w_pix_n = (r_pix_cnt == 7'h7F) ? r_pix_cnt : r_pix_cnt + 7'd1;
        end else if (r_state == LINE && r_px_d) begin
          // The line ends when the valid pixel qualifier drops. This also
          // covers vsync falling while href is still high.
          w_state_n = BLANK;
          if (r_pix_cnt != W7) w_err_n = 1'b1;
          w_line_n = (r_line_cnt == 7'h7F) ? r_line_cnt : r_line_cnt + 7'd1;
          w_pix_n  = '0;
        end
        // The frame-end check uses the already-updated line status, so a
        // line closing in this cycle is counted first.
        if (w_vs_fall) begin
          if (!w_err_n && w_line_n == H7) begin
            w_state_n = HOLD;
            w_fv_n    = 1'b1;
            w_done_n  = 1'b1;
          end else begin
            w_state_n = IDLE;
            w_fv_n    = 1'b0;
            w_gerr_n  = 1'b1;
          end
        end
      end
      SKIP: begin
        if (rd_release) w_fv_n = 1'b0;
        if (w_vs_fall)  w_state_n = w_fv_n ? HOLD : IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pix_cnt     <= '0;
      r_line_cnt    <= '0;
      r_err         <= 1'b0;
      r_frame_valid <= 1'b0;
      r_done        <= 1'b0;
      r_gerr        <= 1'b0;
      r_drop        <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_pix_cnt     <= w_pix_n;
      r_line_cnt    <= w_line_n;
      r_err         <= w_err_n;
      r_frame_valid <= w_fv_n;
      r_done        <= w_done_n;
      r_gerr        <= w_gerr_n;
      r_drop        <= w_drop_n;
    end
  end

  // Buffer write port. Contents survive reset.
  always_ff @(posedge clk) begin
    if (w_we) mem[w_waddr] <= in_data;
  end

  // Registered read port. A read of the address being written returns the
  // old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= ({4'b0, rd_addr} < DEPTH14) ? mem[AW'(rd_addr)] : '0;
    end
  end

`ifdef FM_RX_ERR_CNT_EN
  logic [7:0] r_err_cnt;
  always_ff @(posedge clk) begin
    if (rst)                             r_err_cnt <= 8'd0;
    else if (r_gerr && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
  end
  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 8'd0;
`endif

  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign frame_valid = r_frame_valid;
  assign frame_done  = r_done;
  assign geom_err    = r_gerr;
  assign frame_drop  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_fm_stream_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fm_stream_receiver
// Purpose  : Self-checking bench for fm_stream_receiver (4x4 frame, 16-bit).
//            Read results are checked against a queue of expected words.
//            Event pulses are counted per cycle and compared per scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fm_stream_receiver;

  logic        clk = 1'b0;
  logic        rst, in_vsync, in_href, rd_en, rd_release;
  logic [15:0] in_data;
  logic [9:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid, frame_valid, frame_done, geom_err, frame_drop;
  logic [7:0]  err_cnt;

`ifdef FM_RX_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int n_checks = 0, n_fail = 0;
  int done_cnt = 0, gerr_cnt = 0, drop_cnt = 0;
  int exp_err = 0;
  int d0, g0, p0;
  logic [15:0] exp_q[$];
  logic        rd_en_q = 1'b0;
  logic [15:0] ev;

  fm_stream_receiver #(.FM_WIDTH(4), .FM_HEIGHT(4), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .in_vsync(in_vsync), .in_href(in_href),
    .in_data(in_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_release(rd_release), .rd_data(rd_data), .rd_valid(rd_valid),
    .frame_valid(frame_valid), .frame_done(frame_done), .geom_err(geom_err),
    .frame_drop(frame_drop), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Read data is due exactly one cycle after the strobe.
  always @(posedge clk) rd_en_q <= rd_en;

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (geom_err   === 1'b1) gerr_cnt++;
    if (frame_drop === 1'b1) drop_cnt++;
    if (rd_valid !== 1'b0 || rd_en_q === 1'b1) begin
      n_checks++;
      if (rd_valid !== rd_en_q) begin
        n_fail++;
        $display("FAIL rd_valid: got %b want %b at %0t", rd_valid, rd_en_q, $time);
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_scoreboard: unexpected read data %0d at %0t", rd_data, $time);
      end else begin
        ev = exp_q.pop_front();
        if (rd_data !== ev) begin
          n_fail++;
          $display("FAIL rd_data: got %0d want %0d at %0t", rd_data, ev, $time);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic snap();
    d0 = done_cnt; g0 = gerr_cnt; p0 = drop_cnt;
  endtask

  task automatic send_line(input int base, input int len);
    for (int p = 0; p < len; p++) begin
      in_href = 1'b1; in_data = 16'(base + p); step();
    end
    in_href = 1'b0; in_data = '0;
    idle(16);
  endtask

  // abrupt: vsync drops while href is still high on the last line
  task automatic send_frame(input int nlines, input int short_line, input int base,
                            input bit rel_at_rise, input bit abrupt);
    in_vsync = 1'b1; rd_release = rel_at_rise; step();
    rd_release = 1'b0; step();
    for (int l = 0; l < nlines; l++) begin
      if (abrupt && l == nlines - 1) begin
        for (int p = 0; p < 4; p++) begin
          in_href = 1'b1; in_data = 16'(base + l * 4 + p); step();
        end
        in_vsync = 1'b0; step();
        in_href = 1'b0;
      end else begin
        send_line(base + l * 4, (l == short_line) ? 3 : 4);
      end
    end
    in_vsync = 1'b0; step();
    idle(4);
  endtask

  task automatic read_frame(input int base);
    for (int a = 0; a < 16; a++) begin
      rd_en = 1'b1; rd_addr = 10'(a); exp_q.push_back(16'(base + a)); step();
    end
    rd_en = 1'b0;
    idle(3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rd_drain: %0d reads outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic release_frame();
    rd_release = 1'b1; step();
    rd_release = 1'b0; step();
    n_checks++;
    if (frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL release_fv: got %b want 0", frame_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_vsync = 0; in_href = 0; in_data = 0;
    rd_en = 0; rd_addr = 0; rd_release = 0;
    idle(3);
    n_checks++;
    if ({frame_valid, frame_done, geom_err, frame_drop, rd_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 00000",
               {frame_valid, frame_done, geom_err, frame_drop, rd_valid});
    end
    n_checks++;
    if (rd_data !== 16'd0) begin
      n_fail++; $display("FAIL reset_rd_data: got %0d want 0", rd_data);
    end
    n_checks++;
    if (err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt);
    end
    exp_err = 0;
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_clean_frame();
    snap();
    send_frame(4, -1, 0, 1'b0, 1'b0);
    n_checks++;
    if (done_cnt - d0 != 1 || gerr_cnt - g0 != 0) begin
      n_fail++;
      $display("FAIL clean_pulses: done %0d gerr %0d want 1 0", done_cnt - d0, gerr_cnt - g0);
    end
    n_checks++;
    if (frame_valid !== 1'b1) begin
      n_fail++; $display("FAIL clean_fv: got %b want 1", frame_valid);
    end
    read_frame(0);
  endtask

  task automatic test_frame_drop();
    snap();
    send_frame(4, -1, 100, 1'b0, 1'b0);
    n_checks++;
    if (drop_cnt - p0 != 1 || done_cnt - d0 != 0) begin
      n_fail++;
      $display("FAIL drop_pulses: drop %0d done %0d want 1 0", drop_cnt - p0, done_cnt - d0);
    end
    n_checks++;
    if (frame_valid !== 1'b1) begin
      n_fail++; $display("FAIL drop_fv: got %b want 1", frame_valid);
    end
    read_frame(0);
  endtask

  task automatic test_release_same_cycle();
    snap();
    send_frame(4, -1, 200, 1'b1, 1'b0);
    n_checks++;
    if (done_cnt - d0 != 1 || drop_cnt - p0 != 0) begin
      n_fail++;
      $display("FAIL relrise_pulses: done %0d drop %0d want 1 0", done_cnt - d0, drop_cnt - p0);
    end
    n_checks++;
    if (frame_valid !== 1'b1) begin
      n_fail++; $display("FAIL relrise_fv: got %b want 1", frame_valid);
    end
    read_frame(200);
    release_frame();
  endtask

  task automatic test_short_line();
    snap();
    send_frame(4, 1, 50, 1'b0, 1'b0);
    if (CNT_EN) exp_err++;
    n_checks++;
    if (gerr_cnt - g0 != 1 || done_cnt - d0 != 0) begin
      n_fail++;
      $display("FAIL short_pulses: gerr %0d done %0d want 1 0", gerr_cnt - g0, done_cnt - d0);
    end
    n_checks++;
    if (frame_valid !== 1'b0 || err_cnt !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL short_state: fv %b err_cnt %0d want 0 %0d", frame_valid, err_cnt, exp_err);
    end
  endtask

  task automatic test_extra_line();
    snap();
    send_frame(5, -1, 300, 1'b0, 1'b0);
    if (CNT_EN) exp_err++;
    n_checks++;
    if (gerr_cnt - g0 != 1 || done_cnt - d0 != 0) begin
      n_fail++;
      $display("FAIL extra_pulses: gerr %0d done %0d want 1 0", gerr_cnt - g0, done_cnt - d0);
    end
    n_checks++;
    if (frame_valid !== 1'b0 || err_cnt !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL extra_state: fv %b err_cnt %0d want 0 %0d", frame_valid, err_cnt, exp_err);
    end
    // A fifth line written anyway would alias onto the first words.
    read_frame(300);
  endtask

  task automatic test_reset_mid_frame();
    snap();
    in_vsync = 1'b1; step(); step();
    send_line(400, 4);
    rst = 1'b1; idle(2); rst = 1'b0;
    exp_err = 0;
    for (int l = 1; l < 4; l++) send_line(400 + l * 4, 4);
    in_vsync = 1'b0; step();
    idle(4);
    n_checks++;
    if (gerr_cnt - g0 != 0 || done_cnt - d0 != 0 || frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_abandon: gerr %0d done %0d fv %b want 0 0 0",
               gerr_cnt - g0, done_cnt - d0, frame_valid);
    end
    n_checks++;
    if (err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL midrst_err_cnt: got %0d want 0", err_cnt);
    end
    snap();
    send_frame(4, -1, 500, 1'b0, 1'b0);
    n_checks++;
    if (done_cnt - d0 != 1 || gerr_cnt - g0 != 0 || frame_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_recover: done %0d gerr %0d fv %b want 1 0 1",
               done_cnt - d0, gerr_cnt - g0, frame_valid);
    end
    read_frame(500);
  endtask

  task automatic test_vsync_fall_in_line();
    release_frame();
    snap();
    send_frame(4, -1, 600, 1'b0, 1'b1);
    n_checks++;
    if (done_cnt - d0 != 1 || gerr_cnt - g0 != 0 || frame_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL vsfall_frame: done %0d gerr %0d fv %b want 1 0 1",
               done_cnt - d0, gerr_cnt - g0, frame_valid);
    end
    read_frame(600);
  endtask

  task automatic test_out_of_range();
    rd_en = 1'b1; rd_addr = 10'd16;   exp_q.push_back(16'd0); step();
    rd_addr = 10'd1023;               exp_q.push_back(16'd0); step();
    rd_addr = 10'd5;                  exp_q.push_back(16'd605); step();
    rd_en = 1'b0;
    idle(3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL oor_drain: %0d reads outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_frame_drop();
    test_release_same_cycle();
    test_short_line();
    test_extra_line();
    test_reset_mid_frame();
    test_vsync_fall_in_line();
    test_out_of_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
